// File: rtl/gpio_y_sequencer.sv
// Fabric-side Y pin controller: synchronizes and debounces a 2-bit MSS GPIO
// command and drives Y as steady high, steady low, blink or a one-shot low pulse.
module gpio_y_sequencer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned BLINK_HALF   = 250,
  parameter int unsigned PULSE_LEN    = 100
) (
  input  logic       FAB_CCC_GL0,
  input  logic       FAB_RESET_N,
  input  logic       FAB_CCC_LOCK,
  input  logic       GPIO_0_M2F,
  input  logic       GPIO_1_M2F,
  output logic       Y,
  output logic       BUSY,
  output logic       CMD_ACK,
  output logic [2:0] STATE
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam int unsigned LW = $clog2(PULSE_LEN + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_HALF - 1);
  localparam logic [LW-1:0] PULSE_MAX  = LW'(PULSE_LEN);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_IDLE      = 3'd1,
    S_LOW       = 3'd2,
    S_BLINK     = 3'd3,
    S_PULSE     = 3'd4
  } state_t;

  logic [1:0]    gpio_s1, gpio_s2;
  logic          lock_s1, lock_s2;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    candidate, debounced, accepted, accepted_n;
  logic [SW-1:0] stable_cnt;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic [LW-1:0] pulse_cnt, pulse_cnt_n;
  state_t        state, state_n;
  logic          y_n, busy_n, ack_n;

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      gpio_s1 <= {GPIO_1_M2F, GPIO_0_M2F};
      gpio_s2 <= gpio_s1;
      lock_s1 <= FAB_CCC_LOCK;
      lock_s2 <= lock_s1;
    end
  end

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A code change always restarts the stability count, even on a tick cycle.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      candidate  <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
    end else begin
      if (gpio_s2 != candidate) begin
        candidate  <= gpio_s2;
        stable_cnt <= '0;
      end else if (tick && stable_cnt != STABLE_MAX) begin
        stable_cnt <= stable_cnt + SW'(1);
      end
      if (stable_cnt == STABLE_MAX) begin
        debounced <= candidate;
      end
    end
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state     <= S_WAIT_LOCK;
      Y         <= 1'b1;
      BUSY      <= 1'b0;
      CMD_ACK   <= 1'b0;
      accepted  <= '0;
      blink_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_n;
      Y         <= y_n;
      BUSY      <= busy_n;
      CMD_ACK   <= ack_n;
      accepted  <= accepted_n;
      blink_cnt <= blink_cnt_n;
      pulse_cnt <= pulse_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    y_n         = Y;
    ack_n       = 1'b0;
    accepted_n  = accepted;
    blink_cnt_n = blink_cnt;
    pulse_cnt_n = pulse_cnt;
    if (!lock_s2) begin
      state_n     = S_WAIT_LOCK;
      y_n         = 1'b1;
      accepted_n  = '0;
      blink_cnt_n = '0;
      pulse_cnt_n = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          state_n = S_IDLE;
          y_n     = 1'b1;
        end
        S_IDLE, S_LOW, S_BLINK: begin
          if (debounced != accepted) begin
            accepted_n  = debounced;
            ack_n       = 1'b1;
            blink_cnt_n = '0;
            pulse_cnt_n = '0;
            case (debounced)
              2'b00: begin state_n = S_IDLE;  y_n = 1'b1; end
              2'b01: begin state_n = S_LOW;   y_n = 1'b0; end
              2'b10: begin state_n = S_BLINK; y_n = 1'b0; end
              2'b11: begin state_n = S_PULSE; y_n = 1'b0; end
            endcase
          end else if (state == S_BLINK && tick) begin
            if (blink_cnt == BLINK_MAX) begin
              y_n         = ~Y;
              blink_cnt_n = '0;
            end else begin
              blink_cnt_n = blink_cnt + BW'(1);
            end
          end
        end
        S_PULSE: begin
          // The first tick after entry only starts the count, so the low time
          // is never shorter than PULSE_LEN full tick periods.
          if (tick) begin
            if (pulse_cnt == PULSE_MAX) begin
              state_n     = S_IDLE;
              y_n         = 1'b1;
              pulse_cnt_n = '0;
            end else begin
              pulse_cnt_n = pulse_cnt + LW'(1);
            end
          end
        end
        default: begin
          state_n = S_WAIT_LOCK;
          y_n     = 1'b1;
        end
      endcase
    end
    busy_n = (state_n == S_PULSE);
  end

  assign STATE = state;

endmodule
